spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI slave (responder) for our SPI master link: CPOL=1, MSB first, 8-bit frames.
//  Bus timing: sclk idles high; master drives mosi on sclk falling edge and samples miso on rising edge.
//  The slave therefore samples mosi on sclk rising and updates miso on sclk falling.
//  Sits on the peripheral side, oversampling sclk/ss/mosi in the local clk domain.
//  Exchanges bytes with local logic over a valid/ready TX holding register and a 1-cycle RX strobe.
// PARAMETERS
//  DATA_W       8  frame width in bits
//  SYNC_STAGES  2  flop stages on sclk/ss/mosi inputs (>=2)
// PORTS
//  clk          in   1       local clock; must be >= 4x sclk frequency
//  rst          in   1       synchronous, active-high reset
//  sclk         in   1       SPI clock from master, asynchronous
//  ss           in   1       slave select, active low, asynchronous
//  mosi         in   1       master out slave in
//  miso         out  1       slave out (registered)
//  miso_oe      out  1       tri-state enable for miso pad; high while selected
//  tx_data      in   DATA_W  next byte to send
//  tx_valid     in   1       tx_data valid; accepted when tx_valid && tx_ready
//  tx_ready     out  1       TX holding register empty
//  tx_underrun  out  1       1-cycle pulse: byte load found holding reg empty, 0x00 sent
//  rx_data      out  DATA_W  last fully received byte; held until next byte completes
//  rx_valid     out  1       1-cycle pulse: rx_data updated
//  busy         out  1       synchronized ss low (transaction in progress)
// BEHAVIOUR
//  Reset values: miso=0, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, busy=0.
//  Reset also clears shift regs, bit_cnt, holding reg and start flag; FSM to IDLE.
//  Sync: sclk/ss/mosi pass SYNC_STAGES flops; edges detected from last stage vs one extra flop.
//  FSM IDLE:
//   - Synced ss falling -> ACTIVE.
//   - Load tx_shift from holding reg (tx_ready->1), or 0x00 with tx_underrun pulse if empty.
//   - miso <= MSB, miso_oe=1, bit_cnt=0, start=1.
//  FSM ACTIVE:
//   - sclk rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt++; start=0.
//     On the DATA_W-th rise, the next cycle gives rx_data <= assembled byte, rx_valid=1 for 1 cycle;
//     bit_cnt wraps to 0.
//   - sclk fall, bit_cnt!=0: tx_shift shifts left and miso <= next bit.
//   - sclk fall, bit_cnt==0 && start=1: ignored (master's first fall coincides with ss fall).
//   - sclk fall, bit_cnt==0 && start=0: load next byte as at ss fall (back-to-back frames).
//   - Synced ss rising -> IDLE, miso_oe=0, miso=0.
//     A partial byte is discarded (no rx_valid); its TX byte is consumed and lost.
//  Edge-case precedence:
//   - ss edge in same cycle as sclk edge: ss wins.
//   - Edges while in IDLE are ignored.
//  TX write in same cycle as a byte load:
//   - Load sees the pre-write contents (no bypass); the write lands in the holding reg.
//   - tx_valid while tx_ready=0 is ignored; holding reg is never overwritten.
//  Reset mid-transaction:
//   - Immediate return to reset values.
//   - Next transaction starts only on a fresh synced ss falling edge (ss held low through reset is ignored).
//  Latency: pin edge to action = SYNC_STAGES+1 clk; rx_valid one clk after that.
// TESTING
//  1 Preload 0xA5; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_valid once; rx_data=0x3C; tx_ready=1 at ss fall.
//  2 No preload; master sends 0xFF -> miso all 0; tx_underrun one pulse; rx_data=0xFF.
//  3 Two back-to-back bytes under one ss low, 0x12 then 0x34 written after first load.
//    -> master reads 0x12,0x34; two rx_valid pulses.
//  4 ss deasserted after 5 sclk rises -> no rx_valid; miso_oe=0; next full frame received correctly.
//  5 rst asserted mid-byte with ss held low -> outputs at reset values; no activity until ss rises and falls again.
//  6 tx_valid with tx_ready=0 (0x77 while 0x55 held) -> 0x55 transmitted, 0x77 dropped.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave, CPOL=1, MSB first: samples mosi on sclk rise and updates miso on sclk fall.
// The pins are oversampled in the clk domain. TX goes through a one-deep holding register; RX arrives as a 1-cycle strobe.
//
// state  | meaning
// IDLE   | not selected; miso tri-stated, waiting for synced ss fall
// ACTIVE | selected; mosi shifted in on sclk rise, miso shifted out on sclk fall
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sclk,
  input  logic              i_ss,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_tx_underrun,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_tx_underrun;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_done;
  logic              r_rx_valid;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_start;

  logic w_sclk_s, w_ss_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_ss_edge;
  logic w_active, w_begin, w_end, w_sample, w_fall_ok, w_shift, w_load;
  logic w_tx_accept;
  logic [DATA_W-1:0] w_load_byte;

  // The ss chain resets low, so a select held low through reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '1;
      r_sclk_d    <= 1'b1;
      r_ss_sync   <= '0;
      r_ss_d      <= 1'b0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_ss_edge   = w_ss_rise | w_ss_fall;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_ss_fall) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_ss_rise) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_miso_oe = 1'b0;
    o_busy    = 1'b0;
    if (r_state == ST_ACTIVE) begin
      o_miso_oe = 1'b1;
      o_busy    = 1'b1;
    end
  end

  // An ss edge masks any sclk edge in the same cycle.
  assign w_active    = (r_state == ST_ACTIVE);
  assign w_begin     = ~w_active & w_ss_fall;
  assign w_end       = w_active & w_ss_rise;
  assign w_sample    = w_active & ~w_ss_edge & w_sclk_rise;
  assign w_fall_ok   = w_active & ~w_ss_edge & w_sclk_fall;
  assign w_shift     = w_fall_ok & (r_bit_cnt != '0);
  assign w_load      = w_begin | (w_fall_ok & (r_bit_cnt == '0) & ~r_start);
  assign w_tx_accept = i_tx_valid & ~r_hold_full;
  assign w_load_byte = r_hold_full ? r_hold : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_start    <= 1'b0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_done  <= 1'b0;
      r_rx_valid <= r_rx_done;
      if (r_rx_done) r_rx_data <= r_rx_shift;
      if (w_begin) begin
        r_bit_cnt <= '0;
        r_start   <= 1'b1;
      end else if (w_end) begin
        r_bit_cnt <= '0;
        r_start   <= 1'b0;
      end else if (w_sample) begin
        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
        r_start    <= 1'b0;
        if (r_bit_cnt == CNT_LAST) begin
          r_bit_cnt <= '0;
          r_rx_done <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // The MSB of the shifter is miso. A load reads the holding reg before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shift    <= '0;
      r_tx_underrun <= 1'b0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      if (w_load) begin
        r_tx_shift    <= w_load_byte;
        r_tx_underrun <= ~r_hold_full;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
      end else if (w_end) begin
        r_tx_shift <= '0;
      end
      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_tx_accept) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign o_miso        = r_tx_shift[DATA_W-1];
  assign o_tx_ready    = ~r_hold_full;
  assign o_tx_underrun = r_tx_underrun;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;

endmodule
